// File: rtl/regfile_access_arbiter.sv
// regfile_access_arbiter
// Shares a single-port register file between requester A (core sequencer) and
// requester B (debug/bus port). Round-robin arbitration with a valid/ready request
// handshake, one transaction in flight, and sequencing of the register file's
// load/select timing. Each transaction ends in a one-cycle response pulse carrying
// read data (or zero for writes) and an error flag.
module regfile_access_arbiter #(
    parameter int SELECT_WIDTH = 4,
    parameter int REG_WIDTH    = 8,
    parameter int NUM_GPR      = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_aValid,
    input  logic                    i_aWrite,
    input  logic [SELECT_WIDTH-1:0] i_aAddr,
    input  logic [REG_WIDTH-1:0]    i_aWData,
    output logic                    o_aReady,
    output logic                    o_aRspValid,
    input  logic                    i_bValid,
    input  logic                    i_bWrite,
    input  logic [SELECT_WIDTH-1:0] i_bAddr,
    input  logic [REG_WIDTH-1:0]    i_bWData,
    output logic                    o_bReady,
    output logic                    o_bRspValid,
    output logic [REG_WIDTH-1:0]    o_rspData,
    output logic                    o_rspErr,
    output logic                    o_busy,
    output logic                    o_rfLd,
    output logic [SELECT_WIDTH-1:0] o_rfSel,
    output logic [REG_WIDTH-1:0]    o_rfWData,
    input  logic [REG_WIDTH-1:0]    i_rfRData
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Address decodes to a writable general-purpose register.
    function automatic logic is_gpr(input logic [SELECT_WIDTH-1:0] addr);
        return addr < SELECT_WIDTH'(NUM_GPR);
    endfunction

    // Read map: GPRs come from the register file, three constant registers sit
    // above them, everything else reads as zero with the error flag set.
    // Result is {err, data}.
    function automatic logic [REG_WIDTH:0] read_map(input logic [SELECT_WIDTH-1:0] addr,
                                                   input logic [REG_WIDTH-1:0]    rf_data);
        logic [REG_WIDTH:0] res;
        if (is_gpr(addr)) begin
            res = {1'b0, rf_data};
        end else begin
            case (addr)
                SELECT_WIDTH'(4'b1000): res = {1'b0, {REG_WIDTH{1'b0}}};
                SELECT_WIDTH'(4'b1001): res = {1'b0, REG_WIDTH'(1'b1)};
                SELECT_WIDTH'(4'b1010): res = {1'b0, {REG_WIDTH{1'b1}}};
                default:                res = {1'b1, {REG_WIDTH{1'b0}}};
            endcase
        end
        return res;
    endfunction

    state_t                  state_q, state_d;
    logic                    pref_b_q, pref_b_d;      // 1: B wins a tie next time
    logic                    write_q, write_d;
    logic [SELECT_WIDTH-1:0] addr_q, addr_d;
    logic [REG_WIDTH-1:0]    wdata_q, wdata_d;
    logic                    id_q, id_d;              // 0: A owns the transaction, 1: B
    logic                    ld_q, ld_d;
    logic                    a_rsp_q, a_rsp_d;
    logic                    b_rsp_q, b_rsp_d;
    logic [REG_WIDTH-1:0]    rsp_data_q, rsp_data_d;
    logic                    rsp_err_q, rsp_err_d;
    logic                    a_ready_s, b_ready_s;
    logic                    sel_write_s;
    logic [SELECT_WIDTH-1:0] sel_addr_s;
    logic [REG_WIDTH-1:0]    sel_wdata_s;

    // Round-robin grant: only in IDLE, a lone requester always wins, a tie goes
    // to the side not granted last. Held low while reset is asserted.
    always_comb begin
        a_ready_s = 1'b0;
        b_ready_s = 1'b0;
        if ((state_q == ST_IDLE) && !i_rst) begin
            if (i_aValid && (!i_bValid || !pref_b_q)) begin
                a_ready_s = 1'b1;
            end else if (i_bValid) begin
                b_ready_s = 1'b1;
            end else begin
                a_ready_s = 1'b0;
            end
        end else begin
            a_ready_s = 1'b0;
        end
    end

    // Request fields of the granted side, captured on the accept edge.
    always_comb begin
        if (b_ready_s) begin
            sel_write_s = i_bWrite;
            sel_addr_s  = i_bAddr;
            sel_wdata_s = i_bWData;
        end else begin
            sel_write_s = i_aWrite;
            sel_addr_s  = i_aAddr;
            sel_wdata_s = i_aWData;
        end
    end

    // Transaction sequencer: next state, captured request and response values.
    always_comb begin
        state_d    = state_q;
        pref_b_d   = pref_b_q;
        write_d    = write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        id_d       = id_q;
        ld_d       = 1'b0;
        a_rsp_d    = 1'b0;
        b_rsp_d    = 1'b0;
        rsp_data_d = {REG_WIDTH{1'b0}};
        rsp_err_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (a_ready_s || b_ready_s) begin
                    state_d  = ST_ISSUE;
                    pref_b_d = a_ready_s;
                    write_d  = sel_write_s;
                    addr_d   = sel_addr_s;
                    wdata_d  = sel_wdata_s;
                    id_d     = b_ready_s;
                    // Load pulse is registered so it lines up exactly with ISSUE.
                    ld_d     = sel_write_s && is_gpr(sel_addr_s);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (write_q) begin
                    state_d   = ST_RESP;
                    a_rsp_d   = !id_q;
                    b_rsp_d   = id_q;
                    rsp_err_d = !is_gpr(addr_q);
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Register file output is valid now for the select set in ISSUE.
                state_d                 = ST_RESP;
                a_rsp_d                 = !id_q;
                b_rsp_d                 = id_q;
                {rsp_err_d, rsp_data_d} = read_map(addr_q, i_rfRData);
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any transaction in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            pref_b_q   <= 1'b0;
            write_q    <= 1'b0;
            addr_q     <= {SELECT_WIDTH{1'b0}};
            wdata_q    <= {REG_WIDTH{1'b0}};
            id_q       <= 1'b0;
            ld_q       <= 1'b0;
            a_rsp_q    <= 1'b0;
            b_rsp_q    <= 1'b0;
            rsp_data_q <= {REG_WIDTH{1'b0}};
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pref_b_q   <= pref_b_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            id_q       <= id_d;
            ld_q       <= ld_d;
            a_rsp_q    <= a_rsp_d;
            b_rsp_q    <= b_rsp_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign o_aReady    = a_ready_s;
    assign o_bReady    = b_ready_s;
    assign o_aRspValid = a_rsp_q;
    assign o_bRspValid = b_rsp_q;
    assign o_rspData   = rsp_data_q;
    assign o_rspErr    = rsp_err_q;
    assign o_busy      = (state_q != ST_IDLE);
    assign o_rfLd      = ld_q;
    assign o_rfSel     = addr_q;
    assign o_rfWData   = wdata_q;

endmodule
